// File: rtl/mux5_rr_arbiter.sv
// Round-robin arbiter for five requesters sharing one 5:1 mux and its slave.
// Owns the slave handshake and releases an owner that waits too long for slv_ready.
module mux5_rr_arbiter #(
    parameter int TIMEOUT = 64,
    parameter int TW      = $clog2(TIMEOUT + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] req,
    input  logic       slv_ready,
    output logic       slv_valid,
    output logic [4:0] gnt,
    output logic [2:0] sel,
    output logic [4:0] done,
    output logic       err,
    output logic [2:0] err_id
);
    // Handshake: a transfer moves when slv_valid & slv_ready are both high on a rising
    // clk edge; slv_valid never waits on slv_ready, and it drops as soon as the owner drops req.

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state, state_nx;
    logic [2:0]    ptr, ptr_nx, sel_nx, err_id_nx;
    logic [4:0]    gnt_nx, cand;
    logic          err_nx, complete, win_ok;
    logic [2:0]    win;
    logic [TW-1:0] wdog, wdog_nx;

    assign slv_valid = (state == BUSY) && req[sel];
    assign complete  = slv_valid & slv_ready;
    assign done      = gnt & {5{complete}};

    // The current owner is masked so a completing transfer hands off without a bubble.
    assign cand = (state == IDLE) ? req : (req & ~gnt);

    // Scan from ptr downwards in priority so the entry closest to ptr is written last.
    always_comb begin
        win_ok = 1'b0;
        win    = 3'd0;
        for (int k = 4; k >= 0; k--) begin
            int idx;
            idx = int'(ptr) + k;
            if (idx >= 5) idx = idx - 5;
            if (cand[idx]) begin
                win_ok = 1'b1;
                win    = 3'(idx);
            end
        end
    end

    always_comb begin
        state_nx  = state;
        gnt_nx    = gnt;
        sel_nx    = sel;
        ptr_nx    = ptr;
        wdog_nx   = wdog;
        err_nx    = 1'b0;
        err_id_nx = err_id;
        case (state)
            IDLE: begin
                if (win_ok) begin
                    state_nx = BUSY;
                    gnt_nx   = 5'b00001 << win;
                    sel_nx   = win;
                    ptr_nx   = (win == 3'd4) ? 3'd0 : win + 3'd1;
                    wdog_nx  = '0;
                end
            end
            BUSY: begin
                if (complete) begin
                    if (win_ok) begin
                        gnt_nx  = 5'b00001 << win;
                        sel_nx  = win;
                        ptr_nx  = (win == 3'd4) ? 3'd0 : win + 3'd1;
                        wdog_nx = '0;
                    end else begin
                        state_nx = IDLE;
                        gnt_nx   = 5'b00000;
                    end
                end else if (!req[sel]) begin
                    state_nx = IDLE;
                    gnt_nx   = 5'b00000;
                end else if (wdog == TW'(TIMEOUT - 1)) begin
                    // ptr already points past this owner, so the others get served first.
                    state_nx  = IDLE;
                    gnt_nx    = 5'b00000;
                    err_nx    = 1'b1;
                    err_id_nx = sel;
                end else begin
                    wdog_nx = wdog + TW'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                gnt_nx   = 5'b00000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            gnt    <= 5'b00000;
            sel    <= 3'd0;
            ptr    <= 3'd0;
            wdog   <= '0;
            err    <= 1'b0;
            err_id <= 3'd0;
        end else begin
            state  <= state_nx;
            gnt    <= gnt_nx;
            sel    <= sel_nx;
            ptr    <= ptr_nx;
            wdog   <= wdog_nx;
            err    <= err_nx;
            err_id <= err_id_nx;
        end
    end

endmodule

// File: tb/tb_mux5_rr_arbiter.sv
// Bench for mux5_rr_arbiter: directed scenarios and random traffic checked against
// an owner/pointer/age reference model through an expected-output queue.
module tb_mux5_rr_arbiter;
  localparam int TIMEOUT = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] req;
  logic       slv_ready;
  logic       slv_valid;
  logic [4:0] gnt;
  logic [2:0] sel;
  logic [4:0] done;
  logic       err;
  logic [2:0] err_id;

  mux5_rr_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .slv_ready (slv_ready),
    .slv_valid (slv_valid),
    .gnt       (gnt),
    .sel       (sel),
    .done      (done),
    .err       (err),
    .err_id    (err_id)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model: owner index (-1 = nobody), next search start, cycles waited
  int m_owner, m_ptr, m_age, m_sel, m_err_id;
  bit m_err;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  logic [17:0] exp_q[$];

  function automatic void model_reset();
    m_owner = -1; m_ptr = 0; m_age = 0; m_sel = 0; m_err = 0; m_err_id = 0;
  endfunction

  function automatic int model_pick(input logic [4:0] mask);
    for (int k = 0; k < 5; k++) begin
      int i;
      i = (m_ptr + k) % 5;
      if (mask[i]) return i;
    end
    return -1;
  endfunction

  function automatic void model_grant(input int w);
    m_owner = w; m_sel = w; m_ptr = (w + 1) % 5; m_age = 0;
  endfunction

  // expected outputs for the cycle now in progress, packed {gnt,sel,valid,done,err,err_id}
  function automatic logic [17:0] model_outputs(input logic [4:0] r, input logic rdy);
    logic [4:0] g, d;
    logic v;
    g = (m_owner >= 0) ? 5'(1 << m_owner) : 5'b0;
    v = (m_owner >= 0) && r[m_owner];
    d = (v && rdy) ? g : 5'b0;
    return {g, 3'(m_sel), v, d, m_err, 3'(m_err_id)};
  endfunction

  function automatic void model_advance(input logic [4:0] r, input logic rdy);
    int w;
    m_err = 0;
    if (m_owner < 0) begin
      w = model_pick(r);
      if (w >= 0) model_grant(w);
    end else if (r[m_owner] && rdy) begin
      w = model_pick(r & ~5'(1 << m_owner));
      if (w >= 0) model_grant(w);
      else m_owner = -1;
    end else if (!r[m_owner]) begin
      m_owner = -1;
    end else if (m_age == TIMEOUT - 1) begin
      m_err = 1; m_err_id = m_owner; m_owner = -1;
    end else begin
      m_age++;
    end
  endfunction

  // driver: change inputs just after the edge, then queue what the DUT must show
  task automatic step(input logic [4:0] r, input logic rdy, input logic rs);
    @(posedge clk);
    #1;
    req = r; slv_ready = rdy; rst_n = rs;
    if (!rs) model_reset();
    exp_q.push_back(model_outputs(r, rdy));
    if (rs) model_advance(r, rdy);
  endtask

  // scoreboard monitor, sampling on the falling edge
  always @(negedge clk) begin
    logic [17:0] e, a;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {gnt, sel, slv_valid, done, err, err_id};
      tests_run++;
      if (a !== e) begin
        tests_failed++;
        $display("FAIL cycle %0d: got gnt=%b sel=%0d valid=%b done=%b err=%b err_id=%0d, expected gnt=%b sel=%0d valid=%b done=%b err=%b err_id=%0d",
                 cyc, a[17:13], a[12:10], a[9], a[8:4], a[3], a[2:0],
                 e[17:13], e[12:10], e[9], e[8:4], e[3], e[2:0]);
      end
    end
  end

  initial begin
    logic [4:0] r;
    rst_n = 1'b0; req = 5'b11111; slv_ready = 1'b0;
    model_reset();

    // reset with everybody requesting, then release into full back-to-back rotation
    step(5'b11111, 1'b0, 1'b0);
    step(5'b11111, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) step(5'b11111, 1'b1, 1'b1);
    step(5'b00000, 1'b0, 1'b1);
    step(5'b00000, 1'b0, 1'b1);

    // single requester completing on its third busy cycle
    step(5'b00100, 1'b0, 1'b1);
    step(5'b00100, 1'b0, 1'b1);
    step(5'b00100, 1'b0, 1'b1);
    step(5'b00100, 1'b1, 1'b1);
    step(5'b00000, 1'b0, 1'b1);
    step(5'b00000, 1'b0, 1'b1);

    // lone requester starved by the slave: timeout, one idle cycle, re-grant
    for (int i = 0; i < 22; i++) step(5'b01000, 1'b0, 1'b1);
    step(5'b00000, 1'b0, 1'b1);
    step(5'b00000, 1'b0, 1'b1);

    // owner abandons on its second busy cycle
    step(5'b00010, 1'b0, 1'b1);
    step(5'b00010, 1'b0, 1'b1);
    step(5'b00000, 1'b0, 1'b1);
    step(5'b00000, 1'b0, 1'b1);

    // reset in the middle of a transfer by owner 4, pointer restarts at 0
    step(5'b10000, 1'b0, 1'b1);
    step(5'b10000, 1'b0, 1'b1);
    step(5'b10000, 1'b0, 1'b0);
    step(5'b10001, 1'b0, 1'b0);
    step(5'b10001, 1'b0, 1'b1);
    step(5'b10001, 1'b1, 1'b1);
    step(5'b10001, 1'b1, 1'b1);
    step(5'b00000, 1'b0, 1'b1);

    // random traffic: busy slave, then a mostly stalled slave to provoke timeouts
    r = 5'b00000;
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < 5; b++) begin
        if (r[b]) begin
          if ($urandom_range(0, 15) == 0) r[b] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          r[b] = 1'b1;
        end
      end
      if (i < 400) step(r, ($urandom_range(0, 3) != 0), 1'b1);
      else         step(r, ($urandom_range(0, 9) == 0), 1'b1);
    end

    // let the monitor drain the last expectation
    @(posedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
